sram_controller: RTL
====================

# sram_controller

Responder side of the pipeline's data-memory handshake. The MEM stage issues word reads and writes and stalls on `ready`. This block serves each request over a 16-bit asynchronous external SRAM as two halfword accesses, then holds `ready` low until the access finishes. `ready` inverted is the pipeline-wide `pause`.

## Interface
Parameters:
- `WAIT_CYCLES`, default 3: extra cycles after the two halfword phases; must be ≥1.

Ports:
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: reset, synchronous and active-high.
- `wr_en`  in  1: word write request from MEM stage; held until `ready`.
- `rd_en`  in  1: word read request from MEM stage; held until `ready`.
- `address`  in  32: byte address (ALU result); bits [1:0] ignored.
- `write_data`  in  32: store data (reg2 value).
- `read_data`  out  32: load data; valid in the cycle `ready`=1 completes a read; held afterwards.
- `ready`  out  1: 0 = stall pipeline (drives `pause` = ~`ready`).
- `SRAM_DQ`  inout  16: SRAM data bus.
- `SRAM_ADDR`  out  18: SRAM halfword address.
- `SRAM_WE_N`  out  1: write enable, active low.
- `SRAM_OE_N`  out  1: output enable, active low.
- `SRAM_CE_N`, `SRAM_UB_N`, `SRAM_LB_N`  out  1 each: tied 0 (always selected, both bytes).

## Operation
- Address map: `base` = {`address`[18:2], 1'b0}.
  - Low half at `SRAM_ADDR` = `base`.
  - High half at `SRAM_ADDR` = `base` | 1.
  - Bits [31:19] are ignored.
- `wr_en` has priority when both `wr_en` and `rd_en` are asserted; the request is treated as a write.
- FSM states: IDLE, LOW, HIGH, WAIT, DONE.
  - IDLE → LOW when `rd_en|wr_en`; otherwise stays in IDLE.
  - LOW → HIGH.
  - HIGH → WAIT.
  - WAIT counts `WAIT_CYCLES` cycles, then → DONE.
  - DONE → IDLE unconditionally.
- LOW, write: `SRAM_ADDR`=`base`, `SRAM_DQ`=`write_data`[15:0], `SRAM_WE_N`=0.
- LOW, read: `SRAM_ADDR`=`base`, `SRAM_OE_N`=0; `read_data`[15:0] captures `SRAM_DQ` at the end of LOW.
- HIGH: same as LOW, using `base`|1 and `write_data`/`read_data` bits [31:16].
- Outside LOW/HIGH writes: `SRAM_DQ` is high-Z and `SRAM_WE_N`=1.
- Outside LOW/HIGH reads: `SRAM_OE_N`=1.
- `ready` is combinational: `ready` = 0 when (`rd_en|wr_en`) and state ≠ DONE; `ready` = 1 otherwise.
  - No request present: `ready`=1.
- Wait counter: 0 on entry to WAIT, incremented each WAIT cycle; width clog2(`WAIT_CYCLES`)+1.

## Timing
- Reset values:
  - state IDLE, counter 0, `read_data`=0.
  - `SRAM_WE_N`=1, `SRAM_OE_N`=1, `SRAM_DQ` high-Z, `SRAM_ADDR`=0.
  - `ready` follows its combinational rule, i.e. 1 when idle.
- Request latency: the request is first seen in IDLE (cycle 1); `ready`=1 in cycle 4+`WAIT_CYCLES` (cycle 7 at default 3). The pipeline advances at the end of that cycle.
- Back-to-back memory instructions:
  - The next request is seen in the cycle after DONE, with the FSM in IDLE.
  - One full access per request; no overlap.
- Requester holds `address`, `write_data`, `rd_en` and `wr_en` stable while `ready`=0.
- Request dropped mid-access (e.g. flush): the FSM still completes the sequence to DONE, and a started write still completes.
- Reset mid-access: the next cycle is IDLE with bus released. A half-written word is acceptable; no partial `read_data` update after reset.
- `read_data` changes only at the end of a read's LOW and HIGH cycles.

## Configuration
- `SRAM_FAST_WRITE_EN` defined: write requests skip WAIT (HIGH → DONE). The write asserts `ready` in cycle 4; reads are unchanged.
- `SRAM_FAST_WRITE_EN` undefined: reads and writes share the full latency of 4+`WAIT_CYCLES` cycles.

## Test plan
- Write then read:
  - Write `address`=0x0000_0404, `write_data`=0xDEAD_BEEF → `SRAM_ADDR` 0x202 gets 0xBEEF and 0x203 gets 0xDEAD; `ready` rises in cycle 7.
  - Subsequent read of the same address → `read_data`=0xDEAD_BEEF in the `ready` cycle.
- Idle bus: no request for 10 cycles → `ready`=1, `SRAM_WE_N`=`SRAM_OE_N`=1, DQ high-Z throughout.
- Simultaneous `rd_en`=`wr_en`=1, `write_data`=0x1234_5678 → write performed, `read_data` unchanged; a later read returns 0x1234_5678.
- Back-to-back accesses:
  - Two consecutive reads to 0x100 and 0x104 → two separate 7-cycle stall windows with exactly one `ready`=1 cycle between them.
  - Data correct for both reads.
- Reset mid-access: assert `rst` during HIGH of a read → next cycle IDLE, `read_data`=0, bus released; a fresh read completes normally.
- Fast-write build: with `SRAM_FAST_WRITE_EN` defined, a write gives `ready`=1 in cycle 4 and a read still gives `ready`=1 in cycle 7.

Source files
------------

// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - 32-bit MEM-stage responder over a 16-bit async SRAM, two halfword phases
// Optional SRAM_FAST_WRITE_EN: write requests skip the WAIT phase (HIGH -> DONE).
module sram_controller #(
  parameter int WAIT_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
);

  localparam int CNT_W = $clog2(WAIT_CYCLES) + 1;

  typedef enum logic [2:0] {S_IDLE, S_LOW, S_HIGH, S_WAIT, S_DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] wait_cnt;
  logic             op_write;
  logic [17:0]      base;
  logic [31:0]      wdata;
  logic             request;
  logic             dq_oe;
  logic [15:0]      dq_out;

  assign request = rd_en | wr_en;

  // The request is latched in IDLE so a dropped request still finishes its access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      read_data <= '0;
      op_write  <= 1'b0;
      base      <= '0;
      wdata     <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= (state == S_WAIT) ? wait_cnt + 1'b1 : '0;
      if (state == S_IDLE && request) begin
        op_write <= wr_en;
        base     <= {address[18:2], 1'b0};
        wdata    <= write_data;
      end
      if (state == S_LOW && !op_write) read_data[15:0] <= SRAM_DQ;
      if (state == S_HIGH && !op_write) read_data[31:16] <= SRAM_DQ;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (request) state_next = S_LOW;
      S_LOW:  state_next = S_HIGH;
`ifdef SRAM_FAST_WRITE_EN
      S_HIGH: state_next = op_write ? S_DONE : S_WAIT;
`else
      S_HIGH: state_next = S_WAIT;
`endif
      S_WAIT: if (wait_cnt == CNT_W'(WAIT_CYCLES - 1)) state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    ready     = !(request && state != S_DONE);
    SRAM_ADDR = '0;
    SRAM_WE_N = 1'b1;
    SRAM_OE_N = 1'b1;
    dq_oe     = 1'b0;
    dq_out    = '0;
    if (state == S_LOW || state == S_HIGH) begin
      SRAM_ADDR = (state == S_HIGH) ? (base | 18'd1) : base;
      if (op_write) begin
        SRAM_WE_N = 1'b0;
        dq_oe     = 1'b1;
        dq_out    = (state == S_HIGH) ? wdata[31:16] : wdata[15:0];
      end else begin
        SRAM_OE_N = 1'b0;
      end
    end
  end

  assign SRAM_DQ   = dq_oe ? dq_out : 16'bz;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

endmodule
